// File: rtl/memory_arbiter_pkg.sv
// Shared defaults and grant encoding for the three-port memory arbiter.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 1;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_W    = 2'd1;
    localparam logic [1:0] GNT_A    = 2'd2;
    localparam logic [1:0] GNT_B    = 2'd3;

    // Bit 0 = writer, bit 1 = reader A, bit 2 = reader B.
    function automatic logic [1:0] grant_code(input logic [2:0] onehot);
        logic [1:0] code;
        code = GNT_NONE;
        if (onehot[0])
            code = GNT_W;
        else if (onehot[1])
            code = GNT_A;
        else if (onehot[2])
            code = GNT_B;
        return code;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: W -> A -> B -> W, with the last winner
// dropping to lowest priority.
module rr_arbiter3
    import memory_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    // ptr names the requester that currently has highest priority.
    logic [1:0] ptr;

    // Scan requesters starting at ptr and pick the first one asking.
    always_comb begin
        grant = 3'b000;
        case (ptr)
            GNT_A: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            GNT_B: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

    // Hand top priority to the requester after the winner; idle cycles keep it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= GNT_W;
        end else begin
            case (grant_code(grant))
                GNT_W:   ptr <= GNT_A;
                GNT_A:   ptr <= GNT_B;
                GNT_B:   ptr <= GNT_W;
                default: ptr <= ptr;
            endcase
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one writer and two readers onto a single memory port. All
// memory-side signals are registered; read data comes back through a
// per-reader valid pipeline matched to the memory read latency.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iWrReq,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    output logic              oWrAck,
    input  logic              iRdReqA,
    input  logic [ADDR_W-1:0] iRdAddrA,
    output logic              oRdAckA,
    output logic [DATA_W-1:0] oRdDataA,
    output logic              oRdValidA,
    input  logic              iRdReqB,
    input  logic [ADDR_W-1:0] iRdAddrB,
    output logic              oRdAckB,
    output logic [DATA_W-1:0] oRdDataB,
    output logic              oRdValidB,
    output logic              oMemWriteEnable,
    output logic [ADDR_W-1:0] oMemAddress,
    output logic [DATA_W-1:0] oMemDataIn,
    output logic              oMemReadtoa,
    output logic              oMemReadtob,
    input  logic [DATA_W-1:0] iMemDataOuta,
    input  logic [DATA_W-1:0] iMemDataOutb
);

    logic [2:0]      req_live;
    logic [2:0]      grant;
    logic [RD_LAT:0] pipe_a;
    logic [RD_LAT:0] pipe_b;

    // A requester being acked this cycle is not eligible again until next cycle.
    assign req_live = {iRdReqB & ~oRdAckB, iRdReqA & ~oRdAckA, iWrReq & ~oWrAck};

    rr_arbiter3 u_rr (
        .clk   (Clock),
        .reset (Reset),
        .req   (req_live),
        .grant (grant)
    );

    assign oRdValidA = pipe_a[RD_LAT];
    assign oRdValidB = pipe_b[RD_LAT];

    // Register the winner's strobe, ack, address and write data; idle holds address/data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oWrAck          <= 1'b0;
            oRdAckA         <= 1'b0;
            oRdAckB         <= 1'b0;
            oMemWriteEnable <= 1'b0;
            oMemReadtoa     <= 1'b0;
            oMemReadtob     <= 1'b0;
            oMemAddress     <= '0;
            oMemDataIn      <= '0;
        end else begin
            oWrAck          <= grant[0];
            oRdAckA         <= grant[1];
            oRdAckB         <= grant[2];
            oMemWriteEnable <= grant[0];
            oMemReadtoa     <= grant[1];
            oMemReadtob     <= grant[2];
            case (grant_code(grant))
                GNT_W: begin
                    oMemAddress <= iWrAddr;
                    oMemDataIn  <= iWrData;
                end
                GNT_A:   oMemAddress <= iRdAddrA;
                GNT_B:   oMemAddress <= iRdAddrB;
                default: oMemAddress <= oMemAddress;
            endcase
        end
    end

    // Track each visible read strobe until its data is ready; reset drops in-flight reads.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_a <= {pipe_a[RD_LAT-1:0], oMemReadtoa};
            pipe_b <= {pipe_b[RD_LAT-1:0], oMemReadtob};
        end
    end

    // Capture memory output in the cycle it is valid so it lines up with the valid pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oRdDataA <= '0;
            oRdDataB <= '0;
        end else begin
            if (pipe_a[RD_LAT-1])
                oRdDataA <= iMemDataOuta;
            if (pipe_b[RD_LAT-1])
                oRdDataB <= iMemDataOutb;
        end
    end

endmodule
